// File: rtl/if_id_buffer.sv
// Fetch-to-decode decoupling buffer: a small FIFO of {instruction, PC+4} pairs
// with flush on redirect, fetch back-pressure and a saturating bubble counter.
module if_id_buffer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             ClockPulse,
    input  logic             Reset,
    input  logic [31:0]      Instruction,
    input  logic [31:0]      NextPc,
    input  logic             Hit,
    input  logic             PcSource,
    input  logic             Stall,
    output logic             FetchHold,
    output logic             IdValid,
    output logic [31:0]      IdInstruction,
    output logic [31:0]      IdNextPc,
    output logic [5:0]       Opcode,
    output logic [4:0]       Rs,
    output logic [4:0]       Rt,
    output logic [4:0]       Rd,
    output logic [4:0]       Shamt,
    output logic [5:0]       Funct,
    output logic [15:0]      Imm16,
    output logic [CNT_W-1:0] BubbleCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      instrMem [DEPTH];
    logic [31:0]      pcMem    [DEPTH];
    logic [PTR_W-1:0] readPtr;
    logic [PTR_W-1:0] writePtr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    // Status depends only on the registered count, so fetch never sees a
    // combinational path from this cycle's inputs.
    assign FetchHold = (count == FULL_COUNT);
    assign IdValid   = (count != '0);

    assign push = Hit & ~FetchHold & ~PcSource;
    assign pop  = IdValid & ~Stall & ~PcSource;

    assign IdInstruction = IdValid ? instrMem[readPtr] : 32'h0;
    assign IdNextPc      = IdValid ? pcMem[readPtr]    : 32'h0;

    assign Opcode = IdInstruction[31:26];
    assign Rs     = IdInstruction[25:21];
    assign Rt     = IdInstruction[20:16];
    assign Rd     = IdInstruction[15:11];
    assign Shamt  = IdInstruction[10:6];
    assign Funct  = IdInstruction[5:0];
    assign Imm16  = IdInstruction[15:0];

    // Stale storage is harmless because outputs are masked when empty.
    always_ff @(posedge ClockPulse) begin
        if (push) begin
            instrMem[writePtr] <= Instruction;
            pcMem[writePtr]    <= NextPc;
        end
    end

    always_ff @(posedge ClockPulse) begin
        if (Reset || PcSource) begin
            count    <= '0;
            readPtr  <= '0;
            writePtr <= '0;
        end else begin
            if (push) begin
                writePtr <= writePtr + 1'b1;
            end
            if (pop) begin
                readPtr <= readPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Survives flushes on purpose so redirect bubbles are counted too.
    always_ff @(posedge ClockPulse) begin
        if (Reset) begin
            BubbleCount <= '0;
        end else if (!IdValid && (BubbleCount != '1)) begin
            BubbleCount <= BubbleCount + 1'b1;
        end
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Decoupling stage between instruction fetch and decode. Captures each fetched instruction and its NextPc (PC+4) into a small FIFO, presents the oldest entry to the decode stage with pre-split MIPS fields, and back-pressures fetch when full. Branch redirects (PcSource) flush the buffer. A cache miss (Hit low) inserts a bubble rather than a bogus instruction.

## Interface
- DEPTH, 2, number of FIFO entries (power of two, ≥2)
- CNT_W, 16, width of the bubble statistics counter
- ClockPulse  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Instruction  in  32  instruction word from fetch
- NextPc  in  32  PC+4 belonging to Instruction
- Hit  in  1  fetch word valid (cache hit) this cycle
- PcSource  in  1  branch taken / redirect: flush
- Stall  in  1  decode cannot accept the head entry this cycle
- FetchHold  out  1  buffer full; fetch must hold its PC
- IdValid  out  1  head entry valid
- IdInstruction  out  32  head instruction; 32'h0 (sll $0 nop) when empty
- IdNextPc  out  32  head NextPc; 0 when empty
- Opcode  out  6  IdInstruction[31:26]
- Rs  out  5  IdInstruction[25:21]
- Rt  out  5  IdInstruction[20:16]
- Rd  out  5  IdInstruction[15:11]
- Shamt  out  5  IdInstruction[10:6]
- Funct  out  6  IdInstruction[5:0]
- Imm16  out  16  IdInstruction[15:0]
- BubbleCount  out  CNT_W  cycles with IdValid=0, saturating

## Operation
- Storage: DEPTH entries of {Instruction, NextPc}, read pointer, write pointer, and a count of 0..DEPTH. Pointers wrap modulo DEPTH.
- push = Hit & ~FetchHold & ~PcSource.
- pop = IdValid & ~Stall & ~PcSource.
- FetchHold = (count == DEPTH). It is combinational from registered count only and has no path from any input.
- IdValid = (count != 0). IdInstruction and IdNextPc come from the head entry, forced to 0 when empty.
- Field outputs are pure bit slices of IdInstruction, so they read all-zero when empty.
- Count update:
  - push only: +1
  - pop only: −1
  - both: unchanged; head advances, and the new entry is written at the tail
  - neither: unchanged
- Flush: PcSource=1 at an edge sets count=0 and rptr=wptr=0, and discards the incoming word. Flush overrides push, pop and Stall.
- Full and pop in the same cycle: there is no push that cycle because FetchHold=1. Count becomes DEPTH−1 and FetchHold drops on the next cycle.
- Empty with Stall=1: nothing to pop, and a push still proceeds.
- Hit=0: no push. A bubble propagates naturally.
- BubbleCount: increments at each edge where IdValid=0 (sampled before the edge) and holds at 2^CNT_W−1. It is not cleared by flush, only by Reset.
- Reset: count, pointers and BubbleCount go to 0. Storage contents are don't-care but masked, because outputs are forced to 0 when empty. Reset overrides flush.

## Timing
- Reset values:
  - FetchHold=0, IdValid=0
  - IdInstruction=0, IdNextPc=0, all field outputs 0
  - BubbleCount=0
- Latency: a word pushed at edge k is visible on IdInstruction after edge k when the buffer was empty. Cut-through is not allowed: same-cycle input never reaches the outputs.
- Throughput: one instruction per cycle sustained when Stall=0 and Hit=1.
- The downstream stage samples IdInstruction/IdValid at the edge where pop occurs.
- Redirect: on the cycle after PcSource=1, IdValid=0. The first branch-target word can appear one cycle after fetch delivers it with Hit=1.
- Reset asserted mid-stream empties the buffer at that edge, regardless of Hit, Stall or PcSource.

## Test plan
- Reset then stream: Reset 2 cycles, then Hit=1 with Instruction 0x20080001, 0x20090002, 0x01095020 (NextPc 4, 8, 12), Stall=0.
  - Required: the three words appear on consecutive cycles, one cycle late, with matching NextPc.
  - For 0x01095020: Rs=8, Rt=9, Rd=10, Funct=0x20.
- Back-pressure, DEPTH=2: Stall=1 while pushing 0xA, 0xB, 0xC.
  - Required: FetchHold=1 after the second push, and 0xC is not captured.
  - Then drop Stall: 0xA and 0xB drain in order, and FetchHold=0 after the first pop.
- Flush: two entries queued, pulse PcSource=1 with Hit=1 and Instruction 0xDEAD.
  - Required next cycle: IdValid=0, IdInstruction=0, FetchHold=0, and 0xDEAD is never output.
- Miss bubbles: Hit pattern 1,0,0,1 with Stall=0.
  - Required: IdValid pattern 1,0,0,1, delayed one cycle.
  - BubbleCount increases by exactly the number of sampled empty cycles.
- Simultaneous push/pop at count=1.
  - Required: count stays 1, order is preserved, and no entry is lost or duplicated across pointer wrap over 10 consecutive instructions.
- Saturation/reset, CNT_W=4: idle 20 cycles.
  - Required: BubbleCount=15 and holds.
  - Then assert Reset with one entry queued: BubbleCount=0 and IdValid=0 the following cycle.
